noc_outport_arbiter: RTL and testbench
======================================

Name: noc_outport_arbiter

Overview:
- One output port of the 5-port mesh router. Merges the per-input valid/data muxing into a single block with a wormhole packet lock.
- Collects flits from N_IN input buffers whose route field selects this port. Arbitrates round-robin between packets and holds the grant until the tail flit has passed.
- Drives a registered output stage with a valid/ready handshake toward the link or local sink.
- Generalises the earlier fixed 5-way combinational valid mux: width, input count and port identity are parameters; arbitration, locking and buffering are new.

Parameters:
- N_IN, 5, number of input ports (index 0=N, 1=S, 2=E, 3=W, 4=L).
- DATA_W, 32, flit payload width in bits.
- MY_DIR, 3'b000, route code owned by this output (N=000, S=001, E=010, W=011, L=100; 111=none, never requested).
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid_i  in  N_IN  flit present at input i.
- in_route_i  in  3*N_IN  route code of input i (bits 3i+2:3i).
- in_tail_i  in  N_IN  flit at input i is the last flit of its packet.
- in_data_i  in  DATA_W*N_IN  payload of input i.
- in_pop_o  out  N_IN  one-hot; input i's flit is consumed this cycle.
- out_valid_o  out  1  output register holds a flit.
- out_data_o  out  DATA_W  registered payload.
- out_tail_o  out  1  registered tail flag.
- out_src_o  out  3  index of the input that supplied the flit.
- out_ready_i  in  1  downstream accepts the flit this cycle.
- busy_o  out  1  packet lock held.
- pkt_cnt_o  out  CNT_W  tail flits delivered downstream, wraps.

Behaviour:
- Request: req[i] = in_valid_i[i] && in_route_i[i]==MY_DIR. Route 111, or any code other than MY_DIR, never requests.
- Load enable: ld = !out_valid_o || out_ready_i. This allows one flit per cycle at full throughput.
- States: IDLE and LOCKED(owner).
- IDLE with ld and any req:
  - Winner = first requesting index at or after rr_ptr, searching cyclically (rr_ptr wraps at N_IN-1 to 0).
  - Winner is loaded into the output register and in_pop_o[winner] is asserted in the same cycle (combinational).
  - If the winner's tail=1: stay IDLE and set rr_ptr = winner+1 mod N_IN.
  - If tail=0: go to LOCKED(winner).
- LOCKED with ld and req[owner]: load owner's flit and pop it.
  - If tail=1: go to IDLE with rr_ptr = owner+1 mod N_IN.
  - Requests from other inputs are ignored while locked.
- LOCKED with the owner not requesting (valid low, or route mismatch): no load. Lock is held; output bubbles if drained.
- No ld (output full, ready low): in_pop_o is all zero. Output register, state and rr_ptr hold. out_data_o must not change while out_valid_o=1 and out_ready_i=0.
- Drain without refill (ld with no eligible request): out_valid_o goes to 0 next cycle.
- Latency: 1 cycle from in_pop_o to out_valid_o. At most one bit of in_pop_o is set in any cycle.
- pkt_cnt_o increments when out_valid_o && out_ready_i && out_tail_o, and wraps from 2^CNT_W-1 to 0.
- busy_o = (state == LOCKED).
- Reset (asynchronous, any time, including mid-packet) sets:
  - state = IDLE, rr_ptr = 0;
  - out_valid_o = 0, out_data_o = 0, out_tail_o = 0, out_src_o = 0;
  - pkt_cnt_o = 0, busy_o = 0, in_pop_o = 0.
  - A partial packet is discarded; recovering upstream is outside this block's scope.

Test Plan:
- Single flit: MY_DIR=010, reset done, input 1 presents valid, route=010, tail=1, data=0xA5A5_0001, ready=1 -> in_pop_o=00010 that cycle; next cycle out_valid_o=1, data=0xA5A5_0001, out_src_o=1, tail=1; pkt_cnt_o=1 after accept; busy_o stays 0.
- Round robin: inputs 0, 2 and 4 each send continuous 1-flit packets to MY_DIR, ready=1 -> pop order 0, 2, 4, 0, 2, 4; each input served once every 3 cycles.
- Wormhole lock: input 3 sends a 4-flit packet (tail on flit 4) while input 0 requests continuously -> pops 3, 3, 3, 3, then 0. busy_o=1 from the cycle after the first pop until the tail is popped. Repeat with a 2-cycle gap in input 3's valid -> lock holds, input 0 is not served during the gap.
- Backpressure: output full, out_ready_i=0 for 5 cycles with input 1 requesting -> in_pop_o=0 and out_data_o stable throughout; when ready rises, the next flit is popped in the same cycle as the accept.
- Non-matching route: input 2 has valid=1, route=111, and input 4 has route!=MY_DIR -> no pops, out_valid_o stays 0.
- Reset mid-packet: assert rst after 2 of 4 flits from input 0 -> all outputs 0 and busy_o=0 immediately. After release, input 1 (1-flit packet) is granted first because rr_ptr=0 and input 0 is idle.

Source files
------------

// File: rtl/noc_outport_arbiter_if.sv
// rtl/noc_outport_arbiter_if.sv - flit bundle between router inputs, one output port arbiter and its link
//
// Purpose: groups the input-side flit signals, the pop strobes, the registered
// output stage and the status outputs of one router output port.
// Ports (interface signals):
//   in_valid_i  [N_IN]         flit present at input i
//   in_route_i  [3*N_IN]       route code of input i, bits 3i+2:3i
//   in_tail_i   [N_IN]         flit at input i is the packet tail
//   in_data_i   [DATA_W*N_IN]  payload of input i
//   in_pop_o    [N_IN]         one-hot consume strobe back to the input buffers
//   out_valid_o / out_data_o / out_tail_o / out_src_o   registered output flit
//   out_ready_i                downstream accepts the output flit
//   busy_o                     wormhole lock held
//   pkt_cnt_o   [CNT_W]        tail flits delivered downstream, wraps
// Modports: master = arbiter side, slave = input buffers plus downstream link.
interface noc_outport_arbiter_if #(
  parameter int N_IN   = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [N_IN-1:0]        in_valid_i;
  logic [3*N_IN-1:0]      in_route_i;
  logic [N_IN-1:0]        in_tail_i;
  logic [DATA_W*N_IN-1:0] in_data_i;
  logic [N_IN-1:0]        in_pop_o;
  logic                   out_valid_o;
  logic [DATA_W-1:0]      out_data_o;
  logic                   out_tail_o;
  logic [2:0]             out_src_o;
  logic                   out_ready_i;
  logic                   busy_o;
  logic [CNT_W-1:0]       pkt_cnt_o;

  modport master (
    input  in_valid_i, in_route_i, in_tail_i, in_data_i, out_ready_i,
    output in_pop_o, out_valid_o, out_data_o, out_tail_o, out_src_o,
    output busy_o, pkt_cnt_o
  );

  modport slave (
    output in_valid_i, in_route_i, in_tail_i, in_data_i, out_ready_i,
    input  in_pop_o, out_valid_o, out_data_o, out_tail_o, out_src_o,
    input  busy_o, pkt_cnt_o
  );
endinterface

// File: rtl/noc_outport_arbiter.sv
// rtl/noc_outport_arbiter.sv - mesh router output port: round-robin packet arbiter with wormhole lock
//
// Purpose: selects flits from the inputs whose route code equals MY_DIR,
// arbitrating round-robin between packets and holding the grant until the
// tail flit has been taken, then registers the flit toward the link.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  noc_outport_arbiter_if.master (inputs, pop strobes, output stage, status)
module noc_outport_arbiter #(
  parameter int         N_IN   = 5,
  parameter int         DATA_W = 32,
  parameter logic [2:0] MY_DIR = 3'b000,
  parameter int         CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_outport_arbiter_if.master bus
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_tail;
  logic [2:0]         r_out_src;
  logic [CNT_W-1:0]   r_pkt_cnt;

  logic [N_IN-1:0]    w_req;
  logic               w_ld;
  logic               w_rr_found;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_grant;
  logic [IDX_W-1:0]   w_sel;
  logic               w_sel_tail;
  logic [N_IN-1:0]    w_pop;

  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N_IN - 1)) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_req[i] = bus.in_valid_i[i] && (bus.in_route_i[3*i +: 3] == MY_DIR);
    end
  end

  // Output register can take a new flit when empty or being drained this cycle.
  assign w_ld = !r_out_valid || bus.out_ready_i;

  // First requester at or after r_rr_ptr, searching cyclically.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (!w_rr_found && w_req[(int'(r_rr_ptr) + k) % N_IN]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IDX_W'((int'(r_rr_ptr) + k) % N_IN);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_grant) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_tail) begin
            w_rr_ptr_nxt = f_inc(w_sel);
          end else begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_sel;
          end
        end
        ST_LOCKED: begin
          if (w_sel_tail) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = f_inc(r_owner);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic: grant selection and pop strobe. While locked only the owner
  // can be served; other requesters are ignored. Pops are suppressed during
  // reset because the empty output stage would otherwise enable a load.
  always_comb begin
    w_sel      = '0;
    w_grant    = 1'b0;
    w_sel_tail = 1'b0;
    w_pop      = '0;
    if (r_state == ST_LOCKED) begin
      w_sel   = r_owner;
      w_grant = !rst && w_ld && w_req[r_owner];
    end else begin
      w_sel   = w_rr_idx;
      w_grant = !rst && w_ld && w_rr_found;
    end
    w_sel_tail = bus.in_tail_i[w_sel];
    if (w_grant) begin
      w_pop = N_IN'(1) << w_sel;
    end
  end

  // Output stage: payload only changes on a load, so it stays stable under
  // backpressure; a load cycle with no grant drains the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tail  <= 1'b0;
      r_out_src   <= '0;
    end else if (w_ld) begin
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_out_data <= bus.in_data_i[w_sel*DATA_W +: DATA_W];
        r_out_tail <= w_sel_tail;
        r_out_src  <= 3'(w_sel);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (r_out_valid && bus.out_ready_i && r_out_tail) begin
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign bus.in_pop_o    = w_pop;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_tail_o  = r_out_tail;
  assign bus.out_src_o   = r_out_src;
  assign bus.busy_o      = (r_state == ST_LOCKED);
  assign bus.pkt_cnt_o   = r_pkt_cnt;

endmodule

// File: tb/tb_noc_outport_arbiter.sv
// tb/tb_noc_outport_arbiter.sv - directed self-checking bench for noc_outport_arbiter
module tb_noc_outport_arbiter;
  localparam int         N_IN   = 5;
  localparam int         DATA_W = 32;
  localparam int         CNT_W  = 16;
  localparam logic [2:0] MY_DIR = 3'b010;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  noc_outport_arbiter_if #(.N_IN(N_IN), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  noc_outport_arbiter #(
    .N_IN  (N_IN),
    .DATA_W(DATA_W),
    .MY_DIR(MY_DIR),
    .CNT_W (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int i, input logic v, input logic [2:0] rt,
                        input logic tl, input logic [31:0] d);
    bus.in_valid_i[i]                 = v;
    bus.in_route_i[3*i +: 3]          = rt;
    bus.in_tail_i[i]                  = tl;
    bus.in_data_i[DATA_W*i +: DATA_W] = d;
  endtask

  task automatic clear_all();
    bus.in_valid_i = '0;
    bus.in_route_i = '1;
    bus.in_tail_i  = '0;
    bus.in_data_i  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int ord [3] = '{0, 2, 4};

  initial begin
    rst = 1'b1;
    clear_all();
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    settle();
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_data",  bus.out_data_o,  0);
    chk("rst_tail",  bus.out_tail_o,  0);
    chk("rst_src",   bus.out_src_o,   0);
    chk("rst_busy",  bus.busy_o,      0);
    chk("rst_cnt",   bus.pkt_cnt_o,   0);
    chk("rst_pop",   bus.in_pop_o,    0);
    rst = 1'b0;
    tick();

    // Single flit from input 1
    set_in(1, 1'b1, MY_DIR, 1'b1, 32'hA5A5_0001);
    settle();
    chk("t1_pop",  bus.in_pop_o, 5'b00010);
    chk("t1_busy", bus.busy_o,   0);
    tick();
    set_in(1, 1'b0, MY_DIR, 1'b0, 32'h0);
    settle();
    chk("t1_valid", bus.out_valid_o, 1);
    chk("t1_data",  bus.out_data_o,  32'hA5A5_0001);
    chk("t1_src",   bus.out_src_o,   1);
    chk("t1_tail",  bus.out_tail_o,  1);
    chk("t1_pop0",  bus.in_pop_o,    0);
    chk("t1_busy1", bus.busy_o,      0);
    tick();
    settle();
    chk("t1_cnt",    bus.pkt_cnt_o,   1);
    chk("t1_drain",  bus.out_valid_o, 0);

    // Round robin among inputs 0, 2, 4 from a fresh pointer
    do_reset();
    set_in(0, 1'b1, MY_DIR, 1'b1, 32'h0000_0100);
    set_in(2, 1'b1, MY_DIR, 1'b1, 32'h0000_0102);
    set_in(4, 1'b1, MY_DIR, 1'b1, 32'h0000_0104);
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("rr_pop", bus.in_pop_o, 64'd1 << ord[k % 3]);
      if (k > 0) chk("rr_src", bus.out_src_o, ord[(k - 1) % 3]);
      tick();
    end
    clear_all();
    settle();
    chk("rr_last_src",   bus.out_src_o,   4);
    chk("rr_last_valid", bus.out_valid_o, 1);
    tick();
    settle();
    chk("rr_cnt",   bus.pkt_cnt_o,   6);
    chk("rr_drain", bus.out_valid_o, 0);

    // Wormhole lock: 4-flit packet on input 3 while input 0 keeps requesting
    set_in(3, 1'b1, MY_DIR, 1'b0, 32'h3000_0001);
    settle();
    chk("wl_pop1",  bus.in_pop_o, 5'b01000);
    chk("wl_busy0", bus.busy_o,   0);
    tick();
    set_in(3, 1'b1, MY_DIR, 1'b0, 32'h3000_0002);
    set_in(0, 1'b1, MY_DIR, 1'b1, 32'h0000_00AA);
    settle();
    chk("wl_pop2",  bus.in_pop_o,   5'b01000);
    chk("wl_busy1", bus.busy_o,     1);
    chk("wl_data1", bus.out_data_o, 32'h3000_0001);
    tick();
    set_in(3, 1'b1, MY_DIR, 1'b0, 32'h3000_0003);
    settle();
    chk("wl_pop3", bus.in_pop_o, 5'b01000);
    tick();
    set_in(3, 1'b1, MY_DIR, 1'b1, 32'h3000_0004);
    settle();
    chk("wl_pop4",  bus.in_pop_o, 5'b01000);
    chk("wl_busy4", bus.busy_o,   1);
    tick();
    set_in(3, 1'b0, MY_DIR, 1'b0, 32'h0);
    settle();
    chk("wl_pop_in0", bus.in_pop_o,   5'b00001);
    chk("wl_busy_rel", bus.busy_o,    0);
    chk("wl_tail4",   bus.out_tail_o, 1);
    chk("wl_data4",   bus.out_data_o, 32'h3000_0004);
    tick();

    // Lock holds across a 2-cycle gap in the owner's valid
    set_in(3, 1'b1, MY_DIR, 1'b0, 32'h3100_0001);
    settle();
    chk("gap_pop1", bus.in_pop_o, 5'b01000);
    tick();
    set_in(3, 1'b0, MY_DIR, 1'b0, 32'h0);
    settle();
    chk("gap_pop_a",  bus.in_pop_o, 0);
    chk("gap_busy_a", bus.busy_o,   1);
    tick();
    settle();
    chk("gap_pop_b",    bus.in_pop_o,    0);
    chk("gap_busy_b",   bus.busy_o,      1);
    chk("gap_bubble",   bus.out_valid_o, 0);
    tick();
    set_in(3, 1'b1, MY_DIR, 1'b1, 32'h3100_0002);
    settle();
    chk("gap_pop2", bus.in_pop_o, 5'b01000);
    tick();
    set_in(3, 1'b0, MY_DIR, 1'b0, 32'h0);
    settle();
    chk("gap_pop_in0", bus.in_pop_o, 5'b00001);
    chk("gap_busy_rel", bus.busy_o,  0);
    tick();
    clear_all();
    tick();
    tick();

    // Backpressure: output full, ready low for 5 cycles
    bus.out_ready_i = 1'b0;
    set_in(1, 1'b1, MY_DIR, 1'b1, 32'hB000_0001);
    settle();
    chk("bp_pop_first", bus.in_pop_o, 5'b00010);
    tick();
    set_in(1, 1'b1, MY_DIR, 1'b1, 32'hB000_0002);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_pop",   bus.in_pop_o,    0);
      chk("bp_data",  bus.out_data_o,  32'hB000_0001);
      chk("bp_valid", bus.out_valid_o, 1);
      tick();
    end
    bus.out_ready_i = 1'b1;
    settle();
    chk("bp_pop_accept", bus.in_pop_o,   5'b00010);
    chk("bp_data_accept", bus.out_data_o, 32'hB000_0001);
    tick();
    clear_all();
    settle();
    chk("bp_data_next", bus.out_data_o, 32'hB000_0002);
    chk("bp_src_next",  bus.out_src_o,  1);
    tick();
    tick();

    // Non-matching routes never request
    set_in(2, 1'b1, 3'b111, 1'b1, 32'hDEAD_0002);
    set_in(4, 1'b1, 3'b000, 1'b1, 32'hDEAD_0004);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("nm_pop",   bus.in_pop_o,    0);
      chk("nm_valid", bus.out_valid_o, 0);
      tick();
    end
    clear_all();
    settle();
    // 6 (round robin) + 4 (lock tests) + 2 (backpressure) tails delivered
    chk("cnt_total", bus.pkt_cnt_o, 12);
    tick();

    // Reset in the middle of a 4-flit packet from input 0
    set_in(0, 1'b1, MY_DIR, 1'b0, 32'hC000_0001);
    settle();
    chk("mr_pop1", bus.in_pop_o, 5'b00001);
    tick();
    set_in(0, 1'b1, MY_DIR, 1'b0, 32'hC000_0002);
    settle();
    chk("mr_pop2", bus.in_pop_o, 5'b00001);
    tick();
    set_in(0, 1'b1, MY_DIR, 1'b0, 32'hC000_0003);
    settle();
    chk("mr_busy_pre", bus.busy_o,     1);
    chk("mr_data_pre", bus.out_data_o, 32'hC000_0002);
    rst = 1'b1;
    settle();
    chk("mr_pop",   bus.in_pop_o,    0);
    chk("mr_valid", bus.out_valid_o, 0);
    chk("mr_busy",  bus.busy_o,      0);
    chk("mr_data",  bus.out_data_o,  0);
    chk("mr_tail",  bus.out_tail_o,  0);
    chk("mr_src",   bus.out_src_o,   0);
    chk("mr_cnt",   bus.pkt_cnt_o,   0);
    tick();
    rst = 1'b0;
    set_in(0, 1'b0, MY_DIR, 1'b0, 32'h0);
    set_in(1, 1'b1, MY_DIR, 1'b1, 32'hD000_0001);
    set_in(3, 1'b1, MY_DIR, 1'b1, 32'hD000_0003);
    set_in(4, 1'b1, MY_DIR, 1'b1, 32'hD000_0004);
    settle();
    chk("mr_post_pop", bus.in_pop_o, 5'b00010);
    tick();
    clear_all();
    settle();
    chk("mr_post_src",  bus.out_src_o,  1);
    chk("mr_post_data", bus.out_data_o, 32'hD000_0001);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
